// File: rtl/fp_pkg.sv
// Shared constants and FSM state encoding for the floating-point operand aligner.
package fp_pkg;

    localparam int EXP_W      = 8;
    localparam int SIG_W      = 23;
    localparam int ALIGN_W    = 27;
    localparam int SHIFT_STEP = 8;
    localparam int DIFF_W     = EXP_W + 1;
    localparam int CNT_W      = 5;
    localparam int SHIFT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sticky_shr.sv
// Combinational 27-bit right shifter by 0..8 positions.
// With FP_ALIGN_STICKY_EN defined, every bit shifted out (old bit0 included)
// is OR'd into the result's bit0; otherwise the shift is purely logical.
module sticky_shr
    import fp_pkg::*;
(
    input  logic [ALIGN_W-1:0] value,
    input  logic [SHIFT_W-1:0] shamt,
    output logic [ALIGN_W-1:0] result
);

`ifdef FP_ALIGN_STICKY_EN
    logic [ALIGN_W-1:0] lost_mask;

    // Shift, then fold the lost low bits into the sticky position.
    always_comb begin
        lost_mask = ~({ALIGN_W{1'b1}} << shamt);
        result    = value >> shamt;
        result[0] = result[0] | (|(value & lost_mask));
    end
`else
    // Plain logical shift; shifted-out bits are dropped.
    always_comb begin
        result = value >> shamt;
    end
`endif

endmodule

// File: rtl/fp_align.sv
// Exponent-difference operand aligner for a floating-point adder.
// Captures an operand pair, picks the larger exponent, then shifts the
// smaller significand right by up to 27 places, 8 places per cycle, and
// holds the result until the downstream side takes it.
// Optional feature: define FP_ALIGN_STICKY_EN to accumulate a sticky bit.
module fp_align
    import fp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   exp1_d,
    input  logic [EXP_W-1:0]   exp2_d,
    input  logic [SIG_W-1:0]   sig1,
    input  logic [SIG_W-1:0]   sig2,
    input  logic [1:0]         n_concat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   exp_out,
    output logic [ALIGN_W-1:0] sig_big,
    output logic [ALIGN_W-1:0] sig_small,
    output logic               swapped
);

    // Saturate the 9-bit exponent difference to the full alignment width:
    // anything beyond 27 places shifts the whole significand out anyway.
    function automatic logic [CNT_W-1:0] clamp_diff(input logic [DIFF_W-1:0] d);
        if (d > DIFF_W'(ALIGN_W))
            return CNT_W'(ALIGN_W);
        else
            return d[CNT_W-1:0];
    endfunction

    state_t             state, state_nx;
    logic [CNT_W-1:0]   rem, rem_nx;
    logic               out_valid_nx;
    logic               swap_c;
    logic [DIFF_W-1:0]  diff_raw;
    logic [CNT_W-1:0]   diff_clamp;
    logic [SHIFT_W-1:0] shamt;
    logic [ALIGN_W-1:0] shifted;
    logic [ALIGN_W-1:0] op1, op2;
    logic               capture;

    assign in_ready = (state == IDLE);
    assign capture  = (state == IDLE) && in_valid;
    assign op1      = {n_concat[1], sig1, 3'b000};
    assign op2      = {n_concat[0], sig2, 3'b000};
    assign shamt    = (rem > CNT_W'(SHIFT_STEP)) ? SHIFT_W'(SHIFT_STEP) : rem[SHIFT_W-1:0];

    // Operand ordering and clamped shift distance, computed without wrap-around.
    always_comb begin
        swap_c     = (exp2_d > exp1_d);
        diff_raw   = swap_c ? ({1'b0, exp2_d} - {1'b0, exp1_d})
                            : ({1'b0, exp1_d} - {1'b0, exp2_d});
        diff_clamp = clamp_diff(diff_raw);
    end

    sticky_shr u_shr (
        .value  (sig_small),
        .shamt  (shamt),
        .result (shifted)
    );

    // Next-state and shift-counter logic.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    rem_nx   = diff_clamp;
                    state_nx = (diff_clamp == '0) ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                rem_nx = rem - CNT_W'(shamt);
                if (rem_nx == '0)
                    state_nx = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // out_valid is registered one cycle behind HOLD entry and drops on handshake.
    assign out_valid_nx = (state == HOLD) && !(out_valid && out_ready);

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            rem       <= rem_nx;
            out_valid <= out_valid_nx;
        end
    end

    // Operand capture and per-cycle alignment of the smaller significand.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_out   <= '0;
            sig_big   <= '0;
            sig_small <= '0;
            swapped   <= 1'b0;
        end else if (capture) begin
            swapped   <= swap_c;
            exp_out   <= swap_c ? exp2_d : exp1_d;
            sig_big   <= swap_c ? op2 : op1;
            sig_small <= swap_c ? op1 : op2;
        end else if (state == SHIFT) begin
            sig_small <= shifted;
        end
    end

endmodule

// File: tb/tb_fp_align.sv
// Self-checking bench for fp_align: directed scenarios with literal
// expectations plus randomized operand pairs checked every cycle against a
// transaction-level model (full shift computed in one step, latency by formula).
module tb_fp_align;

`ifdef FP_ALIGN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  exp1_d = '0;
    logic [7:0]  exp2_d = '0;
    logic [22:0] sig1 = '0;
    logic [22:0] sig2 = '0;
    logic [1:0]  n_concat = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  exp_out;
    logic [26:0] sig_big;
    logic [26:0] sig_small;
    logic        swapped;

    fp_align dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp1_d    (exp1_d),
        .exp2_d    (exp2_d),
        .sig1      (sig1),
        .sig2      (sig2),
        .n_concat  (n_concat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .sig_big   (sig_big),
        .sig_small (sig_small),
        .swapped   (swapped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          edge_no = 0;
    int          valid_at = 0;
    bit          armed = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_ov = 1'b0;
    bit          m_zero = 1'b0;
    logic [7:0]  m_exp;
    logic [26:0] m_big, m_small;
    logic        m_sw;

    always @(posedge clk) begin
        int d;
        logic [26:0] a, b, sm;
        logic [31:0] mask;
        edge_no++;
        if (!rst_n) begin
            armed = 1'b1; m_busy = 1'b0; m_zero = 1'b1;
            m_exp = '0; m_big = '0; m_small = '0; m_sw = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                a = {n_concat[1], sig1, 3'b000};
                b = {n_concat[0], sig2, 3'b000};
                if (int'(exp2_d) > int'(exp1_d)) begin
                    m_sw = 1'b1; m_exp = exp2_d; m_big = b; sm = a;
                    d = int'(exp2_d) - int'(exp1_d);
                end else begin
                    m_sw = 1'b0; m_exp = exp1_d; m_big = a; sm = b;
                    d = int'(exp1_d) - int'(exp2_d);
                end
                if (d > 27) d = 27;
                mask = (32'd1 << d) - 32'd1;
                m_small = sm >> d;
                if (STICKY && ((32'(sm) & mask) != 32'd0)) m_small[0] = 1'b1;
                valid_at = edge_no + 1 + (d + 7) / 8;
                m_busy = 1'b1;
                m_zero = 1'b0;
            end
        end else if (m_ov && out_ready) begin
            m_busy = 1'b0;
        end
        m_ov = m_busy && (edge_no >= valid_at);
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov || m_zero) begin
                chk("exp_out", 32'(exp_out), 32'(m_exp));
                chk("sig_big", 32'(sig_big), 32'(m_big));
                chk("sig_small", 32'(sig_small), 32'(m_small));
                chk("swapped", 32'(swapped), 32'(m_sw));
            end
        end
    end

    // ---------------- stimulus ----------------
    int          lat;
    logic [7:0]  cap_exp;
    logic [26:0] cap_big, cap_small;
    logic        cap_sw;

    task automatic scramble_inputs();
        in_valid = 1'($urandom);
        exp1_d   = 8'($urandom);
        exp2_d   = 8'($urandom);
        sig1     = 23'($urandom);
        sig2     = 23'($urandom);
        n_concat = 2'($urandom);
    endtask

    task automatic start(input logic [7:0] e1, input logic [7:0] e2,
                         input logic [22:0] s1, input logic [22:0] s2, input logic [1:0] n);
        exp1_d = e1; exp2_d = e2; sig1 = s1; sig2 = s2; n_concat = n;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_txn(input int hold, input bit scr);
        lat = 0;
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && lat < 12) begin
            if (scr) scramble_inputs();
            @(posedge clk); #1;
            lat++;
        end
        chk("valid_within_bound", 32'(out_valid), 32'd1);
        cap_exp = exp_out; cap_big = sig_big; cap_small = sig_small; cap_sw = swapped;
        repeat (hold) begin
            if (scr) scramble_inputs();
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        if (scr) begin scramble_inputs(); in_valid = 1'b1; end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e2, mode;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sig_small", 32'(sig_small), 32'd0);
        chk("reset_exp_out", 32'(exp_out), 32'd0);

        // basic shift by 3
        start(8'h85, 8'h82, 23'h0, 23'h0, 2'b11);
        finish_txn(0, 1'b0);
        chk("basic_lat", 32'(lat), 32'd2);
        chk("basic_exp", 32'(cap_exp), 32'h85);
        chk("basic_sw", 32'(cap_sw), 32'd0);
        chk("basic_big", 32'(cap_big), 32'h4000000);
        chk("basic_small", 32'(cap_small), 32'h0800000);

        // swap, shift by 8
        start(8'h10, 8'h18, 23'h0, 23'h0, 2'b11);
        finish_txn(0, 1'b0);
        chk("swap_lat", 32'(lat), 32'd2);
        chk("swap_sw", 32'(cap_sw), 32'd1);
        chk("swap_exp", 32'(cap_exp), 32'h18);
        chk("swap_small", 32'(cap_small), 32'h0040000);

        // large difference, clamped to 27
        start(8'h40, 8'h22, 23'h0, 23'h7FFFFF, 2'b11);
        finish_txn(0, 1'b0);
        chk("large_lat", 32'(lat), 32'd5);
        chk("large_small", 32'(cap_small), STICKY ? 32'h1 : 32'h0);

        // zero difference
        start(8'h01, 8'h01, 23'h123456, 23'h55AA33, 2'b00);
        finish_txn(0, 1'b0);
        chk("zero_lat", 32'(lat), 32'd1);
        chk("zero_small", 32'(cap_small), 32'({1'b0, 23'h55AA33, 3'b000}));
        chk("zero_sw", 32'(cap_sw), 32'd0);

        // backpressure with garbage inputs while busy
        start(8'h85, 8'h82, 23'h0ABCDE, 23'h012345, 2'b10);
        finish_txn(3, 1'b1);
        chk("bp_exp", 32'(cap_exp), 32'h85);

        // reset during SHIFT
        start(8'h40, 8'h22, 23'h1, 23'h7FFFFF, 2'b11);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_sig_small", 32'(sig_small), 32'd0);
        chk("rst_mid_sig_big", 32'(sig_big), 32'd0);
        chk("rst_mid_swapped", 32'(swapped), 32'd0);
        repeat (6) @(posedge clk);
        #1;

        // randomized pairs
        for (int i = 0; i < 300; i++) begin
            e1 = int'($urandom_range(0, 255));
            mode = int'($urandom_range(0, 3));
            if (mode == 0) e2 = e1;
            else if (mode == 1) begin
                e2 = e1 + int'($urandom_range(0, 60)) - 30;
                if (e2 < 0) e2 = 0;
                if (e2 > 255) e2 = 255;
            end else e2 = int'($urandom_range(0, 255));
            start(8'(e1), 8'(e2), 23'($urandom), 23'($urandom), 2'($urandom));
            finish_txn(int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_align.md
FP_ALIGN -- requirements
Module: fp_align

Interface
REQ-001 SHALL have input clk, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have input rst_n, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have input in_valid, 1 bit: an operand pair is presented.
REQ-004 SHALL have output in_ready, 1 bit: the block accepts the pair this cycle.
REQ-005 SHALL have inputs exp1_d and exp2_d, 8 bits each: denormal-adjusted exponents from the denorm/zero stage.
REQ-006 SHALL have inputs sig1 and sig2, 23 bits each: stored fractions.
REQ-007 SHALL have input n_concat, 2 bits: implicit leading bits; bit1 belongs to operand 1, bit0 to operand 2.
REQ-008 SHALL have output out_valid, 1 bit, and input out_ready, 1 bit: downstream handshake.
REQ-009 SHALL have output exp_out, 8 bits: the larger exponent.
REQ-010 SHALL have output sig_big, 27 bits: {n, sig, 3'b000} of the larger operand.
REQ-011 SHALL have output sig_small, 27 bits: the aligned smaller operand, with guard, round and sticky in bits [2:0].
REQ-012 SHALL have output swapped, 1 bit: 1 when operand 2 is the larger operand.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and HOLD; in_ready SHALL equal (state==IDLE).
REQ-014 In IDLE with in_valid=1, SHALL capture both operands and set swapped=(exp2_d>exp1_d).
- Equal exponents SHALL give swapped=0.
REQ-015 On capture, SHALL form both operands as {n_bit, sig, 3'b000}; sig_big and exp_out SHALL take the larger operand's value and exponent.
REQ-016 On capture, SHALL compute diff=|exp1_d-exp2_d| and load the remaining-shift counter with min(diff, 27).
REQ-017 From IDLE, SHALL go to HOLD if the clamped diff is 0; otherwise SHALL go to SHIFT.
REQ-018 Each SHIFT cycle, SHALL shift sig_small right by s=min(rem, 8) and decrement rem by s.
- The new bit0 SHALL be the shifted bit0 OR'd with the OR of all s shifted-out bits, including the old bit0.
REQ-019 SHALL leave SHIFT for HOLD in the cycle in which rem reaches 0.
REQ-020 Latency: for a capture at edge N, out_valid SHALL rise after edge N+1+ceil(min(diff,27)/8); the maximum is N+5.
REQ-021 In HOLD, out_valid SHALL be 1 and all data outputs SHALL be stable until out_ready=1.
- On that handshake edge, SHALL return to IDLE with out_valid=0.
- No new pair SHALL be accepted in the same cycle.
REQ-022 in_valid SHALL be ignored outside IDLE.
- Input changes outside IDLE SHALL NOT affect the outputs.
REQ-023 Arithmetic SHALL be unsigned; the exponent difference SHALL be computed at 9 bits before clamping, with no wrap-around.

Reset
REQ-024 With rst_n=0 at a rising edge, state SHALL become IDLE, and out_valid, exp_out, sig_big, sig_small, swapped and the counter SHALL become 0.
REQ-025 A reset asserted during SHIFT or HOLD SHALL discard the operation in progress.
- From the next cycle, in_ready SHALL be 1.
- out_valid SHALL NOT pulse.

Configuration
REQ-026 Macro FP_ALIGN_STICKY_EN defined: sticky accumulation SHALL work as in REQ-018.
REQ-027 Macro FP_ALIGN_STICKY_EN undefined: shifted-out bits SHALL be discarded (plain logical right shift).
- sig_small[0] SHALL carry only shifted data.
- Latency and handshake SHALL be unchanged.

Structure
REQ-028 Package fp_pkg SHALL hold the constants EXP_W=8, SIG_W=23, ALIGN_W=27, SHIFT_STEP=8, and the FSM state enum.
REQ-029 A combinational sub-module sticky_shr SHALL implement the 27-bit right shift by 0..8, with sticky OR under the macro.
- fp_align SHALL instantiate it once.

Verification
REQ-030 Scenario, basic shift: exp1_d=8'h85, exp2_d=8'h82, n_concat=2'b11, sig1=sig2=0, accepted at edge N.
- Expected: exp_out=8'h85, swapped=0, sig_big=27'h4000000, sig_small=27'h0800000.
- Expected: out_valid high after edge N+2.
REQ-031 Scenario, swap with equal-significand step: exp1_d=8'h10, exp2_d=8'h18, n_concat=2'b11.
- Expected: swapped=1, exp_out=8'h18, sig_small=27'h0040000.
- Expected: out_valid after edge N+2.
REQ-032 Scenario, large difference: exp1_d=8'h40, exp2_d=8'h22, n_concat=2'b11, sig2=23'h7FFFFF.
- Expected with the macro: sig_small=27'h0000001, out_valid after edge N+5.
- Expected without the macro: sig_small=0.
REQ-033 Scenario, zero difference: exp1_d=exp2_d=8'h01, n_concat=2'b00.
- Expected: out_valid after edge N+1, sig_small={1'b0, sig2, 3'b000}, swapped=0.
REQ-034 Scenario, backpressure: hold out_ready=0 for 3 cycles in HOLD.
- Expected: outputs stable, in_ready=0, in_valid ignored.
- Expected: returns to IDLE on the edge where out_ready=1.
REQ-035 Scenario, reset mid-shift: rst_n=0 for one cycle during SHIFT.
- Expected: next cycle IDLE, out_valid=0, all outputs 0, in_ready=1.
